// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift engine: op encodings, FSM states
// and default sizes.
package shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 6;
  localparam int MAX_SHIFT = 32;
  localparam int OP_W      = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Rotates take the distance modulo the word size; everything else saturates.
  function automatic logic is_rotate(input logic [OP_W-1:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of a WIDTH-bit word. Unknown op codes behave as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  // Select the single-bit move; SRA replicates the current sign bit.
  always_comb begin
    result = {data[WIDTH-2:0], 1'b0};
    case (op)
      OP_SLL:  result = {data[WIDTH-2:0], 1'b0};
      OP_SRL:  result = {1'b0, data[WIDTH-1:1]};
      OP_SRA:  result = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_ROL:  result = {data[WIDTH-2:0], data[WIDTH-1]};
      OP_ROR:  result = {data[0], data[WIDTH-1:1]};
      default: result = {data[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Iterative shifter: moves the operand one bit per clock under a
// start/busy/done handshake. All outputs come straight from registers.
module shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  // Beyond MAX_SHIFT steps a logical/arithmetic shift no longer changes the
  // word, so the count saturates there; rotates wrap modulo the word size.
  localparam logic [AMT_W-1:0] SAT_AMT  = AMT_W'(MAX_SHIFT);
  localparam logic [AMT_W-1:0] ROT_MASK = AMT_W'(MAX_SHIFT - 1);
  localparam logic [AMT_W-1:0] ONE      = AMT_W'(1);

  state_e            state;
  state_e            next_state;
  logic [AMT_W-1:0]  count;
  logic [AMT_W-1:0]  n_eff;
  logic [OP_W-1:0]   op_q;
  logic [WIDTH-1:0]  step_out;
  logic              accept;

  assign accept = (state == ST_IDLE) && start;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .data   (data_out),
    .result (step_out)
  );

  // Effective number of single-bit steps for the requested operation.
  always_comb begin
    n_eff = amount;
    if (is_rotate(op)) begin
      n_eff = amount & ROT_MASK;
    end else if (amount > SAT_AMT) begin
      n_eff = SAT_AMT;
    end
  end

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (n_eff == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == ONE) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State, handshake flags and the working register; flags are derived from
  // next_state so they are registered alongside the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      op_q     <= OP_SLL;
      data_out <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_IDLE);
      done  <= (next_state == ST_DONE);
      if (accept) begin
        op_q     <= op;
        data_out <= data_in;
        count    <= n_eff;
      end else if (state == ST_SHIFT) begin
        data_out <= step_out;
        count    <= count - ONE;
      end
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine: handshake timing, boundary amounts,
// rotate wrap, reset abort and held-start throughput.
module tb_shift_engine;
  import shift_pkg::*;

  localparam int W = 32;
  localparam int A = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [A-1:0] amount = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_engine #(.WIDTH(W), .AMT_W(A)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble the inputs after acceptance, and check
  // latency (edges after acceptance until done is seen), result and release.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [A-1:0] amt,
                        input logic [W-1:0] din, input logic [W-1:0] exp_res,
                        input int exp_lat, input bit pulse_busy);
    int lat;
    op      = o;
    amount  = amt;
    data_in = din;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    op      = 3'($urandom_range(0, 7));
    amount  = A'($urandom);
    data_in = ~din;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      if (pulse_busy) start = lat[0];
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, data_out, exp_res);
    tick();
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_hold"}, data_out, exp_res);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_data", data_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // Reset in the same cycle as start: start is lost
    reset = 1'b0;
    start = 1'b1; op = OP_SLL; amount = 6'd5; data_in = 32'h1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    check("rst_vs_start_data", data_out, 32'h0);
    tick();
    check("rst_vs_start_idle", 32'(busy), 32'd0);

    // Reset mid-shift
    op = OP_SLL; amount = 6'd10; data_in = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mid_no_done", 32'(done), 32'd0);
    end
    run_op("after_rst", OP_SLL, 6'd10, 32'h1, 32'h0000_0400, 10, 1'b0);

    // Main function and boundaries
    run_op("sll16",   OP_SLL, 6'd16, 32'h0000_ABCD, 32'hABCD_0000, 16, 1'b1);
    run_op("sra4",    OP_SRA, 6'd4,  32'h8000_0000, 32'hF800_0000, 4,  1'b0);
    run_op("srl4",    OP_SRL, 6'd4,  32'h8000_0000, 32'h0800_0000, 4,  1'b0);
    run_op("sra40",   OP_SRA, 6'd40, 32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b1);
    run_op("srl63",   OP_SRL, 6'd63, 32'h8000_0000, 32'h0000_0000, 32, 1'b0);
    run_op("ror1",    OP_ROR, 6'd1,  32'h0000_0001, 32'h8000_0000, 1,  1'b0);
    run_op("rol33",   OP_ROL, 6'd33, 32'h8000_0001, 32'h0000_0003, 1,  1'b0);
    run_op("zero",    OP_SLL, 6'd0,  32'h1234_5678, 32'h1234_5678, 0,  1'b0);
    run_op("sll32",   OP_SLL, 6'd32, 32'hFFFF_FFFF, 32'h0000_0000, 32, 1'b0);
    run_op("op_dflt", 3'b111, 6'd4,  32'h0000_0001, 32'h0000_0010, 4,  1'b0);
    run_op("ror32",   OP_ROR, 6'd32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0,  1'b0);
    run_op("rol4",    OP_ROL, 6'd4,  32'h1234_5678, 32'h2345_6781, 4,  1'b0);
    run_op("sra_pos", OP_SRA, 6'd1,  32'h4000_0000, 32'h2000_0000, 1,  1'b0);
    run_op("srl1",    OP_SRL, 6'd1,  32'h0000_0003, 32'h0000_0001, 1,  1'b0);

    // Held start: accepted at k, k+5, k+10, k+15
    op = OP_SLL; amount = 6'd3; data_in = 32'h0000_0001; start = 1'b1;
    tick();
    for (int c = 1; c < 20; c++) begin
      tick();
      check("held_done", 32'(done), ((c % 5) == 3) ? 32'd1 : 32'd0);
      check("held_busy", 32'(busy), ((c % 5) == 4) ? 32'd0 : 32'd1);
      if ((c % 5) == 3) check("held_res", data_out, 32'h0000_0008);
    end
    start = 1'b0;
    tick();
    check("held_end_busy", 32'(busy), 32'd0);
    check("held_end_data", data_out, 32'h0000_0008);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
